// File: rtl/shift_register_univ_cnt.sv
// shift_register_univ_cnt: WIDTH-bit universal shift register with counted-shift command sequencing
// Ports:
//   CLK                rising-edge clock
//   Clear              synchronous active-high reset, highest priority
//   mode[2:0]          per-step action select (hold/shr/shl/load/ror/rol/asr/hold)
//   start              command strobe, sampled only in IDLE
//   count[CNT_W-1:0]   number of steps for a counted command
//   I_par[WIDTH-1:0]   parallel load data
//   MSB_in, LSB_in     serial inputs for shift right / shift left
//   A_par[WIDTH-1:0]   register contents
//   MSB_out, LSB_out   A_par[WIDTH-1], A_par[0]
//   busy               high while a counted command runs
//   done               one-cycle completion pulse (accepted or rejected command)
module shift_register_univ_cnt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] I_par,
    input  logic             MSB_in,
    input  logic             LSB_in,
    output logic [WIDTH-1:0] A_par,
    output logic             MSB_out,
    output logic             LSB_out,
    output logic             busy,
    output logic             done
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a_n, step;
    logic [CNT_W-1:0] remaining, rem_n;
    logic [2:0]       op_mode, op_n, act;
    logic             done_n, is_shift;

    // In RUN the latched op_mode drives the datapath; live mode is ignored.
    assign act = (state == RUN) ? op_mode : mode;
    assign is_shift = mode inside {3'b001, 3'b010, 3'b100, 3'b101, 3'b110};

    always_comb begin
        step = A_par;
        case (act)
            3'b001:  step = {MSB_in, A_par[WIDTH-1:1]};
            3'b010:  step = {A_par[WIDTH-2:0], LSB_in};
            3'b011:  step = I_par;
            3'b100:  step = {A_par[0], A_par[WIDTH-1:1]};
            3'b101:  step = {A_par[WIDTH-2:0], A_par[WIDTH-1]};
            3'b110:  step = {A_par[WIDTH-1], A_par[WIDTH-1:1]};
            default: step = A_par;
        endcase
    end

    always_comb begin
        state_n = state;
        a_n     = A_par;
        rem_n   = remaining;
        op_n    = op_mode;
        done_n  = 1'b0;
        if (state == RUN) begin
            a_n   = step;
            rem_n = remaining - CNT_W'(1);
            if (remaining == CNT_W'(1)) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
        end else if (start) begin
            // A start holds A_par; invalid commands complete immediately.
            if (is_shift && count != '0) begin
                op_n    = mode;
                rem_n   = count;
                state_n = RUN;
            end else begin
                done_n = 1'b1;
            end
        end else begin
            a_n = step;
        end
    end

    always_ff @(posedge CLK) begin
        if (Clear) begin
            state     <= IDLE;
            A_par     <= '0;
            remaining <= '0;
            op_mode   <= 3'b000;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            A_par     <= a_n;
            remaining <= rem_n;
            op_mode   <= op_n;
            done      <= done_n;
        end
    end

    assign busy    = (state == RUN);
    assign MSB_out = A_par[WIDTH-1];
    assign LSB_out = A_par[0];
endmodule

// File: tb/tb_shift_register_univ_cnt.sv
// tb_shift_register_univ_cnt: directed bench for shift_register_univ_cnt
module tb_shift_register_univ_cnt;
    logic       CLK = 1'b0;
    logic       Clear, start, MSB_in, LSB_in;
    logic [2:0] mode;
    logic [3:0] count;
    logic [7:0] I_par, A_par;
    logic       MSB_out, LSB_out, busy, done;
    int         vectors = 0;
    int         miscompares = 0;

    shift_register_univ_cnt #(.WIDTH(8), .CNT_W(4)) dut (
        .CLK(CLK), .Clear(Clear), .mode(mode), .start(start), .count(count),
        .I_par(I_par), .MSB_in(MSB_in), .LSB_in(LSB_in), .A_par(A_par),
        .MSB_out(MSB_out), .LSB_out(LSB_out), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [7:0] a, input logic b, input logic d);
        chk({tag, ".A_par"}, A_par, a);
        chk({tag, ".busy"}, {7'd0, busy}, {7'd0, b});
        chk({tag, ".done"}, {7'd0, done}, {7'd0, d});
    endtask

    initial begin
        Clear = 1'b1; mode = 3'b011; I_par = 8'hFF; start = 1'b0; count = 4'd0;
        MSB_in = 1'b0; LSB_in = 1'b0;
        tick(); chk3("reset1", 8'h00, 1'b0, 1'b0);
        chk("reset.MSB_out", {7'd0, MSB_out}, 8'd0);
        chk("reset.LSB_out", {7'd0, LSB_out}, 8'd0);
        tick(); chk3("reset2", 8'h00, 1'b0, 1'b0);

        Clear = 1'b0; I_par = 8'hA5;
        tick(); chk("load_A5", A_par, 8'hA5);
        mode = 3'b001; MSB_in = 1'b1;
        tick(); chk("shr1", A_par, 8'hD2);
        tick(); chk("shr2", A_par, 8'hE9);
        tick(); chk("shr3", A_par, 8'hF4);
        chk("shr.MSB_out", {7'd0, MSB_out}, 8'd1);
        chk("shr.LSB_out", {7'd0, LSB_out}, 8'd0);

        mode = 3'b011; I_par = 8'h81; MSB_in = 1'b0;
        tick(); chk("load_81", A_par, 8'h81);
        start = 1'b1; mode = 3'b101; count = 4'd3;
        tick(); chk3("rol.E0", 8'h81, 1'b1, 1'b0);
        start = 1'b0; mode = 3'b000;
        tick(); chk3("rol.E1", 8'h03, 1'b1, 1'b0);
        tick(); chk3("rol.E2", 8'h06, 1'b1, 1'b0);
        tick(); chk3("rol.E3", 8'h0C, 1'b0, 1'b1);
        tick(); chk3("rol.after", 8'h0C, 1'b0, 1'b0);

        mode = 3'b011; I_par = 8'h90;
        tick(); chk("load_90", A_par, 8'h90);
        start = 1'b1; mode = 3'b110; count = 4'd2;
        tick(); chk3("asr.E0", 8'h90, 1'b1, 1'b0);
        start = 1'b0; mode = 3'b011; count = 4'd7; I_par = 8'h00;
        tick(); chk3("asr.E1", 8'hC8, 1'b1, 1'b0);
        start = 1'b1; mode = 3'b001;
        tick(); chk3("asr.E2", 8'hE4, 1'b0, 1'b1);
        start = 1'b0; mode = 3'b000;
        tick(); chk3("asr.after", 8'hE4, 1'b0, 1'b0);

        start = 1'b1; mode = 3'b001; count = 4'd0;
        tick(); chk3("rej_cnt0", 8'hE4, 1'b0, 1'b1);
        start = 1'b0; mode = 3'b000;
        tick(); chk3("rej_cnt0.after", 8'hE4, 1'b0, 1'b0);
        start = 1'b1; mode = 3'b011; count = 4'd4; I_par = 8'h55;
        tick(); chk3("rej_load", 8'hE4, 1'b0, 1'b1);
        start = 1'b0; mode = 3'b000;
        tick(); chk3("rej_load.after", 8'hE4, 1'b0, 1'b0);

        mode = 3'b011; I_par = 8'hF0;
        tick(); chk("load_F0", A_par, 8'hF0);
        start = 1'b1; mode = 3'b010; count = 4'd5; LSB_in = 1'b0;
        tick(); chk3("abort.E0", 8'hF0, 1'b1, 1'b0);
        start = 1'b0;
        tick(); chk3("abort.E1", 8'hE0, 1'b1, 1'b0);
        tick(); chk3("abort.E2", 8'hC0, 1'b1, 1'b0);
        Clear = 1'b1;
        tick(); chk3("abort.clear", 8'h00, 1'b0, 1'b0);
        Clear = 1'b0; mode = 3'b000;
        tick(); chk3("abort.nodone", 8'h00, 1'b0, 1'b0);
        start = 1'b1; mode = 3'b010; count = 4'd1; LSB_in = 1'b1;
        tick(); chk3("shl1.E0", 8'h00, 1'b1, 1'b0);
        start = 1'b0; mode = 3'b000;
        tick(); chk3("shl1.E1", 8'h01, 1'b0, 1'b1);
        tick(); chk3("shl1.after", 8'h01, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/shift_register_univ_cnt.md
# shift_register_univ_cnt

Parametrised universal shift register with counted-shift sequencing. It extends the 4-bit hold/shift/load register to WIDTH bits and adds rotate and arithmetic modes. A start/busy/done command interface runs a programmed number of shift steps autonomously. It sits in the datapath wherever serial/parallel conversion or multi-step shifting is needed under controller handshake.

## Interface
- WIDTH, 8, register width in bits (>= 2)
- CNT_W, 4, width of step-count input and internal remaining counter

- CLK  in  1  clock, all state updates on rising edge
- Clear  in  1  reset, synchronous, active-high
- mode  in  3  operation select (see Operation)
- start  in  1  command strobe, sampled only in IDLE
- count  in  CNT_W  number of shift steps for a counted command
- I_par  in  WIDTH  parallel load data
- MSB_in  in  1  serial input for shift right
- LSB_in  in  1  serial input for shift left
- A_par  out  WIDTH  register contents
- MSB_out  out  1  A_par[WIDTH-1], combinational from register
- LSB_out  out  1  A_par[0], combinational from register
- busy  out  1  high while counted command executes
- done  out  1  one-cycle pulse on command completion

## Operation
- Mode encoding, per-step action:
  - 000: hold
  - 001: logical shift right, {MSB_in, A[W-1:1]}
  - 010: shift left, {A[W-2:0], LSB_in}
  - 011: parallel load, I_par
  - 100: rotate right, {A[0], A[W-1:1]}
  - 101: rotate left, {A[W-2:0], A[W-1]}
  - 110: arithmetic shift right, {A[W-1], A[W-1:1]}
  - 111: reserved, acts as hold
- Shift modes are 001, 010, 100, 101 and 110.
- States are IDLE and RUN, both registered.
- IDLE, start=0:
  - The mode action is applied every edge (free-running, like a classic universal register).
- IDLE, start=1:
  - The mode action is suppressed and A_par holds.
  - If mode is a shift mode and count != 0: latch op_mode <= mode and remaining <= count, then go to RUN.
  - Otherwise the command is rejected: stay IDLE, A_par unchanged, done pulses on the next cycle.
- RUN, each edge:
  - A_par <= op_mode action; remaining <= remaining - 1.
  - When remaining == 1 on that edge: go to IDLE and set done <= 1.
- RUN inputs:
  - mode, start, count and I_par are ignored.
  - MSB_in and LSB_in are sampled live every step.
- Clear has highest priority over every other input:
  - A_par = 0, state = IDLE, remaining = 0, op_mode = 000, busy = 0, done = 0.
  - Clear during RUN aborts the command with no done pulse.
- Reset values: A_par = 0, MSB_out = 0, LSB_out = 0, busy = 0, done = 0.

## Timing
- busy = (state == RUN), registered.
- Accepted command:
  - Start sampled at edge E0. busy is high after E0.
  - Shifts occur at edges E1..En, where n = count.
  - busy falls and done rises after En. done is high for exactly one cycle.
  - Start-to-done latency is count+1 cycles.
- Rejected command (count = 0 or non-shift mode): done is high for the cycle after E0; busy stays 0.
- Back-to-back commands: start may be asserted in the same cycle that done is high; it is accepted because the state is IDLE.
- Maximum command is 2^CNT_W - 1 steps. A count >= WIDTH is legal; rotates wrap, shifts fill with serial or sign bits.
- Free-running IDLE modes have 1-cycle latency from mode/data to A_par.

## Test plan
- Reset: drive Clear=1 for 2 cycles with mode=011 and I_par=FF. Required: A_par=00, busy=0, done=0 after the first edge.
- Load and free shift: mode=011 with I_par=A5 for 1 cycle, then mode=001 with MSB_in=1 for 3 cycles. Required: A_par sequence A5, D2, E9, F4; MSB_out=1 and LSB_out=0 at the end.
- Counted rotate: from A_par=81, start with mode=101 and count=3. Required: busy high for 3 cycles; A_par goes 03, 06, 0C; done is a single pulse in the cycle after A_par reaches 0C, with busy=0 in that cycle.
- Counted arithmetic shift with input disturbance: from A_par=90, start with mode=110 and count=2, then toggle mode and start during RUN. Required: A_par goes C8, E4; done pulses once; the toggled inputs have no effect.
- Rejected commands: start with count=0 and mode=001, then start with count=4 and mode=011. Required: each gives a done pulse one cycle later; busy stays 0; A_par is unchanged in both cases.
- Abort: from A_par=F0, start with mode=010 and count=5, then assert Clear on the third RUN cycle. Required: A_par=00 and busy=0 on the next edge; no done pulse. A new start with mode=010, count=1 and LSB_in=1 then gives A_par=01 and a done pulse.
